multicycle_ctrl_fsm: RTL and testbench



---
 rtl/multicycle_ctrl_fsm_if.sv | 10 +
 rtl/multicycle_ctrl_fsm.sv | 166 ++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_fsm_if.sv
// Memory handshake between the multicycle sequencer (master) and the memory (slave).
interface multicycle_ctrl_fsm_if;
    logic mem_read;
    logic mem_write;
    logic i_or_d;
    logic mem_ready;

    modport master (output mem_read, mem_write, i_or_d, input mem_ready);
    modport slave  (input mem_read, mem_write, i_or_d, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Moore sequencer for the 8-bit multicycle MIPS-style datapath: fetch/decode/execute/
// memory/writeback with memory watchdog, illegal-opcode trap and retired-instruction count.
module multicycle_ctrl_fsm #(
    parameter int OP_W        = 6,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_ctrl_fsm_if.master mem,
    input  logic                 run,
    input  logic [OP_W-1:0]      opcode,
    input  logic                 zero,
    output logic                 ir_write,
    output logic                 pc_en,
    output logic [1:0]           pc_source,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 instr_done,
    output logic [CNT_W-1:0]     instr_count,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [3:0]           state
);
    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADDR = 4'd3,
        S_MEM_RD = 4'd4, S_MEM_WB = 4'd5, S_MEM_WR = 4'd6, S_EXEC_R = 4'd7,
        S_EXEC_I = 4'd8, S_ALU_WB = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11,
        S_TRAP = 4'd15
    } state_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctl_t;

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_SUBI = OP_W'(6'b001001);
    localparam logic [OP_W-1:0] OP_LWI  = OP_W'(6'b001010);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

    localparam int            WW    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic          WD_EN = (MEM_TIMEOUT > 0);
    localparam logic [WW-1:0] WLIM  = WW'(MEM_TIMEOUT);

    state_t          st, nxt;
    logic [OP_W-1:0] op_q, op_nxt;
    ctl_t            ctl_q;
    logic [WW-1:0]   wcnt;
    logic            wait_st, timeout, end_i;

    // Control word for a given state; outputs are registered from the next state.
    function automatic ctl_t decode(input state_t s, input logic [OP_W-1:0] op);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b01; end
            S_DECODE:   c.alu_src_b = 2'b11;
            S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEM_RD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            S_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEM_WR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            S_EXEC_R:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            S_EXEC_I:   begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = (op == OP_SUBI) ? 2'b01 : 2'b00;
            end
            S_ALU_WB:   begin c.reg_write = 1'b1; c.reg_dst = (op == OP_R); end
            S_BRANCH:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
            S_JUMP:     begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
            default:    ;
        endcase
        return c;
    endfunction

    assign wait_st = (st == S_FETCH) || (st == S_MEM_RD) || (st == S_MEM_WR);
    assign timeout = wait_st && !mem.mem_ready && WD_EN && (wcnt == WLIM);

    always_comb begin
        nxt    = st;
        op_nxt = op_q;
        end_i  = 1'b0;
        case (st)
            S_IDLE:     if (run) nxt = S_FETCH;
            S_FETCH:    if (mem.mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                op_nxt = opcode;
                if (opcode == OP_R)                                          nxt = S_EXEC_R;
                else if (opcode == OP_ADDI || opcode == OP_SUBI || opcode == OP_LWI) nxt = S_EXEC_I;
                else if (opcode == OP_LW || opcode == OP_SW)                 nxt = S_MEM_ADDR;
                else if (opcode == OP_BEQ)                                   nxt = S_BRANCH;
                else if (opcode == OP_J)                                     nxt = S_JUMP;
                else                                                         nxt = S_TRAP;
            end
            S_EXEC_R, S_EXEC_I: nxt = S_ALU_WB;
            S_MEM_ADDR: nxt = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem.mem_ready) nxt = S_MEM_WB;
            S_MEM_WR:   end_i = mem.mem_ready;
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: end_i = 1'b1;
            S_TRAP:     nxt = S_TRAP;
            default:    nxt = S_IDLE;
        endcase
        // run only matters at instruction boundaries; a running instruction always completes
        if (end_i)   nxt = run ? S_FETCH : S_IDLE;
        if (timeout) nxt = S_TRAP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= S_IDLE;
            op_q        <= '0;
            ctl_q       <= '0;
            wcnt        <= '0;
            instr_count <= '0;
            trap        <= 1'b0;
            trap_cause  <= 2'b00;
        end else begin
            st    <= nxt;
            op_q  <= op_nxt;
            ctl_q <= decode(nxt, op_nxt);
            // counter is nonzero only while parked in a wait state, so entry clears it for free
            wcnt  <= (wait_st && !mem.mem_ready && WD_EN) ? wcnt + WW'(1) : '0;
            if (end_i) instr_count <= instr_count + CNT_W'(1);
            if (nxt == S_TRAP && st != S_TRAP) begin
                trap       <= 1'b1;
                trap_cause <= timeout ? 2'b10 : 2'b01;
            end
        end
    end

    assign mem.mem_read  = ctl_q.mem_read;
    assign mem.mem_write = ctl_q.mem_write;
    assign mem.i_or_d    = ctl_q.i_or_d;
    assign ir_write      = ctl_q.ir_write & mem.mem_ready;
    assign pc_en         = (ctl_q.pc_write & ((st != S_FETCH) | mem.mem_ready))
                         | (ctl_q.pc_write_cond & zero);
    assign pc_source     = ctl_q.pc_source;
    assign alu_src_a     = ctl_q.alu_src_a;
    assign alu_src_b     = ctl_q.alu_src_b;
    assign alu_op        = ctl_q.alu_op;
    assign reg_write     = ctl_q.reg_write;
    assign reg_dst       = ctl_q.reg_dst;
    assign mem_to_reg    = ctl_q.mem_to_reg;
    assign instr_done    = end_i;
    assign state         = st;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed plan items plus randomized instruction stream
// checked against a per-instruction state-path model.
module tb_multicycle_ctrl_fsm;
    localparam int CNT_W = 16;
    localparam int TMO   = 15;

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_SUBI = 6'b001001,
                           OP_LWI = 6'b001010, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_BAD = 6'b111111;

    logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, zero = 1'b0;
    logic [5:0] opcode = '0;
    logic ir_write, pc_en, alu_src_a, reg_write, reg_dst, mem_to_reg, instr_done, trap;
    logic [1:0] pc_source, alu_src_b, alu_op, trap_cause;
    logic [CNT_W-1:0] instr_count;
    logic [3:0] state;

    int tests = 0;
    int fails = 0;
    logic [CNT_W-1:0] cnt_ref = '0;
    logic idle_ref = 1'b1;

    multicycle_ctrl_fsm_if mif ();

    multicycle_ctrl_fsm #(.OP_W(6), .CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .mem(mif.master), .run(run), .opcode(opcode), .zero(zero),
        .ir_write(ir_write), .pc_en(pc_en), .pc_source(pc_source), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .instr_done(instr_done), .instr_count(instr_count),
        .trap(trap), .trap_cause(trap_cause), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic mrd, mwr, iod, irw, pce;
        logic [1:0] pcs;
        logic asa;
        logic [1:0] asb, aop;
        logic rw, rd, m2r;
    } ctl_t;

    ctl_t obs;
    assign obs = {mif.mem_read, mif.mem_write, mif.i_or_d, ir_write, pc_en, pc_source,
                  alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg};

    // Expected control word per state, taken from the state table.
    function automatic ctl_t exp_ctl(input int st, input logic [5:0] op, input logic mr, input logic z);
        ctl_t c;
        c = '0;
        case (st)
            1:  begin c.mrd = 1'b1; c.asb = 2'b01; c.irw = mr; c.pce = mr; end
            2:  c.asb = 2'b11;
            3:  begin c.asa = 1'b1; c.asb = 2'b10; end
            4:  begin c.mrd = 1'b1; c.iod = 1'b1; end
            5:  begin c.rw = 1'b1; c.m2r = 1'b1; end
            6:  begin c.mwr = 1'b1; c.iod = 1'b1; end
            7:  begin c.asa = 1'b1; c.aop = 2'b10; end
            8:  begin c.asa = 1'b1; c.asb = 2'b10; c.aop = (op == OP_SUBI) ? 2'b01 : 2'b00; end
            9:  begin c.rw = 1'b1; c.rd = (op == OP_R); end
            10: begin c.asa = 1'b1; c.aop = 2'b01; c.pcs = 2'b01; c.pce = z; end
            11: begin c.pce = 1'b1; c.pcs = 2'b10; end
            default: ;
        endcase
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; mif.mem_ready = 1'b0; zero = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        idle_ref = 1'b1;
        cnt_ref  = '0;
    endtask

    // One cycle: drive at negedge, then check state after settling.
    task automatic step(input logic mr, input logic r, input logic [5:0] op, input int exp_st, input string tag);
        @(negedge clk);
        mif.mem_ready = mr; run = r; opcode = op;
        #1;
        chk(tag, 32'(state), 32'(exp_st));
    endtask

    // Whole instruction: the model expands it into its expected state path, wait cycles included.
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input logic z, input logic run_end);
        int path[$];
        logic mrq[$];
        int last;
        if (idle_ref) begin path.push_back(0); mrq.push_back(1'($urandom_range(0, 1))); end
        for (int i = 0; i < wf; i++) begin path.push_back(1); mrq.push_back(1'b0); end
        path.push_back(1); mrq.push_back(1'b1);
        path.push_back(2); mrq.push_back(1'($urandom_range(0, 1)));
        case (op)
            OP_R:                   begin path.push_back(7); path.push_back(9); end
            OP_ADDI, OP_SUBI, OP_LWI: begin path.push_back(8); path.push_back(9); end
            OP_LW: begin
                path.push_back(3);
                for (int i = 0; i < wm; i++) path.push_back(4);
                path.push_back(4); path.push_back(5);
            end
            OP_SW: begin
                path.push_back(3);
                for (int i = 0; i < wm; i++) path.push_back(6);
                path.push_back(6);
            end
            OP_BEQ: path.push_back(10);
            default: path.push_back(11);
        endcase
        while (mrq.size() < path.size()) begin
            int k = mrq.size();
            if ((path[k] == 4 || path[k] == 6) && path[k+1] == path[k]) mrq.push_back(1'b0);
            else if (path[k] == 4 || path[k] == 6) mrq.push_back(1'b1);
            else mrq.push_back(1'($urandom_range(0, 1)));
        end
        last = path.size() - 1;
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            mif.mem_ready = mrq[i];
            zero   = z;
            run    = (i == last) ? run_end : (path[i] == 0 ? 1'b1 : 1'($urandom_range(0, 1)));
            opcode = (path[i] >= 2) ? op : 6'($urandom_range(0, 63));
            #1;
            chk($sformatf("state op%0h c%0d", op, i), 32'(state), 32'(path[i]));
            chk($sformatf("done op%0h c%0d", op, i), 32'(instr_done), 32'(i == last));
            chk($sformatf("ctl op%0h c%0d", op, i), 32'(obs), 32'(exp_ctl(path[i], op, mrq[i], z)));
        end
        cnt_ref  = cnt_ref + 1'b1;
        idle_ref = !run_end;
        @(posedge clk); #1;
        chk($sformatf("next op%0h", op), 32'(state), run_end ? 32'd1 : 32'd0);
        chk($sformatf("count op%0h", op), 32'(instr_count), 32'(cnt_ref));
    endtask

    initial begin
        logic [5:0] ops[8];
        ops = '{OP_R, OP_ADDI, OP_SUBI, OP_LWI, OP_LW, OP_SW, OP_BEQ, OP_J};
        mif.mem_ready = 1'b0;
        #12;
        chk("rst state", 32'(state), 32'd0);
        chk("rst ctl", 32'(obs), 32'd0);
        chk("rst count", 32'(instr_count), 32'd0);
        chk("rst trap", 32'({trap, trap_cause, instr_done}), 32'd0);
        do_reset();

        run_instr(OP_R, 0, 0, 1'b0, 1'b1);
        run_instr(OP_LW, 0, 3, 1'b0, 1'b1);
        run_instr(OP_BEQ, 0, 0, 1'b1, 1'b1);
        run_instr(OP_BEQ, 0, 0, 1'b0, 1'b1);
        run_instr(OP_SW, 1, 2, 1'b0, 1'b0);
        run_instr(OP_SUBI, 2, 0, 1'b1, 1'b1);

        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            int wm;
            op = ops[$urandom_range(0, 7)];
            wm = (op == OP_LW || op == OP_SW) ? int'($urandom_range(0, 3)) : 0;
            run_instr(op, int'($urandom_range(0, 3)), wm, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 4) != 0));
        end

        // reset in the middle of a stalled store
        if (idle_ref) step(1'b1, 1'b1, OP_SW, 0, "mw idle");
        step(1'b1, 1'b1, OP_SW, 1, "mw fetch");
        step(1'b0, 1'b1, OP_SW, 2, "mw decode");
        step(1'b0, 1'b1, OP_SW, 3, "mw addr");
        step(1'b0, 1'b1, OP_SW, 6, "mw wr");
        chk("mw write", 32'(mif.mem_write), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mw rst state", 32'(state), 32'd0);
        chk("mw rst write", 32'(mif.mem_write), 32'd0);
        chk("mw rst count", 32'(instr_count), 32'd0);
        do_reset();

        // illegal opcode trap is sticky until reset
        step(1'b1, 1'b1, OP_BAD, 0, "ill idle");
        step(1'b1, 1'b1, OP_BAD, 1, "ill fetch");
        step(1'b1, 1'b1, OP_BAD, 2, "ill decode");
        for (int i = 0; i < 6; i++) begin
            step(1'($urandom_range(0, 1)), 1'(i % 2), OP_BAD, 15, "ill trap st");
            chk("ill ctl", 32'(obs), 32'd0);
            chk("ill flags", 32'({trap, trap_cause, instr_done}), 32'b1_01_0);
        end
        do_reset();

        // watchdog fires when the limit is reached with mem_ready still low
        step(1'b0, 1'b1, OP_R, 0, "to idle");
        for (int i = 0; i <= TMO; i++) step(1'b0, 1'b1, OP_R, 1, $sformatf("to wait%0d", i));
        step(1'b1, 1'b1, OP_R, 15, "to trap st");
        chk("to ctl", 32'(obs), 32'd0);
        chk("to flags", 32'({trap, trap_cause}), 32'b1_10);
        do_reset();

        // mem_ready on the limit cycle completes the fetch normally
        step(1'b0, 1'b1, OP_R, 0, "lim idle");
        for (int i = 0; i < TMO; i++) step(1'b0, 1'b1, OP_R, 1, $sformatf("lim wait%0d", i));
        step(1'b1, 1'b1, OP_R, 1, "lim last");
        chk("lim irw", 32'({ir_write, pc_en}), 32'b11);
        step(1'b1, 1'b1, OP_R, 2, "lim decode");
        chk("lim trap", 32'({trap, trap_cause}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
